// File: rtl/pattern_state_tracker.sv
// pattern_state_tracker: registers the pattern-recognition next state, detects
// completed "00"/"11" pairs, counts them and queues pair events for logging.
//
// Event port handshake: an entry transfers on a rising edge where ev_valid and
// ev_ready are both high. ev_valid depends only on registered occupancy, never
// on ev_ready, and ev_idx/ev_kind hold the head entry stable until it transfers.
module pattern_state_tracker #(
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [1:0]                    ns,
  output logic [1:0]                    st,
  output logic                          det,
  output logic                          det_kind,
  output logic [CNT_W-1:0]              zero_cnt,
  output logic [CNT_W-1:0]              one_cnt,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [IDX_W-1:0]              ev_idx,
  output logic                          ev_kind,
  output logic [$clog2(FIFO_DEPTH):0]   ev_level,
  output logic                          ev_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  logic hit;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // Detection and FIFO control decisions for this edge.
  always_comb begin
    hit     = 1'b0;
    pop     = 1'b0;
    full    = 1'b0;
    push_ok = 1'b0;
    drop    = 1'b0;
    hit     = in_valid && ((ns == 2'b00) || (ns == 2'b11));
    pop     = (level != '0) && ev_ready;
    full    = (level == LW'(FIFO_DEPTH));
    push_ok = hit && (!full || pop);
    drop    = hit && full && !pop;
  end

  // State register, bit index, detection pulse and saturating pair counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= 2'b00;
      idx      <= '0;
      det      <= 1'b0;
      det_kind <= 1'b0;
      zero_cnt <= '0;
      one_cnt  <= '0;
    end else if (clr) begin
      st       <= 2'b00;
      idx      <= '0;
      det      <= 1'b0;
      det_kind <= 1'b0;
      zero_cnt <= '0;
      one_cnt  <= '0;
    end else begin
      det <= hit;
      if (in_valid) begin
        st       <= ns;
        idx      <= idx + IDX_W'(1);
        det_kind <= ns[1];
        if (hit && !ns[1] && (zero_cnt != '1)) zero_cnt <= zero_cnt + CNT_W'(1);
        if (hit &&  ns[1] && (one_cnt  != '1)) one_cnt  <= one_cnt + CNT_W'(1);
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ev_ovf <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) ev_ovf <= 1'b1;
    end
  end

  // Event storage; stale contents are never visible because reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= {idx, ns[1]};
  end

  // Head-of-queue view, forced to zero while empty.
  always_comb begin
    ev_valid = (level != '0);
    ev_level = level;
    ev_idx   = '0;
    ev_kind  = 1'b0;
    if (level != '0) begin
      ev_idx  = mem[rd_ptr][IDX_W:1];
      ev_kind = mem[rd_ptr][0];
    end
  end

endmodule

// File: tb/tb_pattern_state_tracker.sv
// tb_pattern_state_tracker: drives bit streams through a model of the pattern
// transition function and scores both a default and a 2-bit-counter instance.
module tb_pattern_state_tracker;

  localparam int IDX_W = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] ns = 2'b00;
  logic       ev_ready = 1'b0;

  logic [1:0]       st;
  logic             det, det_kind;
  logic [7:0]       zero_cnt, one_cnt;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_kind;
  logic [2:0]       ev_level;
  logic             ev_ovf;

  logic [1:0]       s_st;
  logic             s_det, s_det_kind;
  logic [1:0]       s_zero_cnt, s_one_cnt;
  logic             s_ev_valid;
  logic [IDX_W-1:0] s_ev_idx;
  logic             s_ev_kind;
  logic [2:0]       s_ev_level;
  logic             s_ev_ovf;

  pattern_state_tracker #(.CNT_W(8), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .ns(ns),
    .st(st), .det(det), .det_kind(det_kind), .zero_cnt(zero_cnt), .one_cnt(one_cnt),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_kind(ev_kind),
    .ev_level(ev_level), .ev_ovf(ev_ovf)
  );

  pattern_state_tracker #(.CNT_W(2), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .ns(ns),
    .st(s_st), .det(s_det), .det_kind(s_det_kind), .zero_cnt(s_zero_cnt), .one_cnt(s_one_cnt),
    .ev_valid(s_ev_valid), .ev_ready(ev_ready), .ev_idx(s_ev_idx), .ev_kind(s_ev_kind),
    .ev_level(s_ev_level), .ev_ovf(s_ev_ovf)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [IDX_W:0] exp_q[$];   // {idx, kind} of pending events
  logic [1:0] m_st;
  logic       m_det, m_kind, m_ovf;
  int         m_zero, m_one, m_idx;
  logic       pend_v, pend_b;   // an unpaired bit is waiting

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_st = 2'b00; m_det = 1'b0; m_kind = 1'b0; m_ovf = 1'b0;
    m_zero = 0; m_one = 0; m_idx = 0;
    pend_v = 1'b0; pend_b = 1'b0;
  endtask

  task automatic check_all();
    logic [IDX_W:0] head;
    chk("st", 32'(st), 32'(m_st));
    chk("det", 32'(det), 32'(m_det));
    if (m_det) chk("det_kind", 32'(det_kind), 32'(m_kind));
    chk("zero_cnt", 32'(zero_cnt), 32'(sat(m_zero, 255)));
    chk("one_cnt", 32'(one_cnt), 32'(sat(m_one, 255)));
    chk("sat_zero_cnt", 32'(s_zero_cnt), 32'(sat(m_zero, 3)));
    chk("sat_one_cnt", 32'(s_one_cnt), 32'(sat(m_one, 3)));
    chk("ev_valid", 32'(ev_valid), 32'(exp_q.size() > 0));
    chk("ev_level", 32'(ev_level), 32'(exp_q.size()));
    chk("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("ev_idx", 32'(ev_idx), 32'(head[IDX_W:1]));
    chk("ev_kind", 32'(ev_kind), 32'(head[0]));
  endtask

  // ---------------- driver ----------------
  // One clock: present inputs, advance the reference, check after the edge.
  task automatic drive_cycle(input logic c, input logic iv, input logic b, input logic rdy);
    logic [1:0] nsv;
    logic       pop, hit;
    int         sz;
    @(negedge clk);
    clr = c; in_valid = iv; ev_ready = rdy;
    // Pattern function: a bit equal to the waiting bit completes a pair.
    if (iv) begin
      if (pend_v && pend_b == b) nsv = {b, b};
      else                       nsv = b ? 2'b10 : 2'b01;
    end else begin
      nsv = 2'($urandom_range(0, 3));
    end
    ns = nsv;
    sz  = exp_q.size();
    pop = (sz > 0) && rdy;
    if (c) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      m_det = 1'b0;
      if (iv) begin
        hit = (nsv == 2'b00) || (nsv == 2'b11);
        m_det = hit; m_kind = nsv[1]; m_st = nsv;
        if (hit) begin
          if (nsv[1]) m_one++; else m_zero++;
          if (sz < DEPTH || pop) exp_q.push_back({IDX_W'(m_idx), nsv[1]});
          else                   m_ovf = 1'b1;
          pend_v = 1'b0;
        end else begin
          pend_v = 1'b1; pend_b = b;
        end
        m_idx = (m_idx + 1) % (1 << IDX_W);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bits(input int n, input logic b, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    check_all();
    rst_n = 1'b1;

    // Two zeros: state 01 then 00, one "00" event at idx 1.
    bits(2, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("pair00_level", 32'(ev_level), 32'd1);
    chk("pair00_idx", 32'(ev_idx), 32'd1);

    // Four ones with consumer ready: events at idx 1 and 3, drained.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    bits(4, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("ones_cnt", 32'(one_cnt), 32'd2);

    // Twelve zeros with consumer stalled: FIFO fills, two events dropped.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    bits(12, 1'b0, 1'b0);
    chk("ovf_set", 32'(ev_ovf), 32'd1);
    chk("zeros_cnt", 32'(zero_cnt), 32'd6);
    idle(5, 1'b1);

    // Full FIFO, new pair in the same cycle as a pop: no drop.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    bits(8, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("full_pop_level", 32'(ev_level), 32'd4);
    idle(5, 1'b1);

    // Ones with input gaps: narrow counter saturates, gaps hold state.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
      idle(1, 1'b1);
    end
    chk("sat_hold", 32'(s_one_cnt), 32'd3);

    // Clear coincident with an accepted bit.
    bits(5, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);

    // Asynchronous reset pulse between edges.
    bits(7, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    idle(1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
